// File: rtl/pu_slave_spi_pkg.sv
// Shared types and sizing helpers for the PU slave SPI controller.
package pu_slave_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SPI_WIDTH  = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_SPI_WIDTH;

  function automatic int bytes_per_word(input int dw, input int sw);
    return dw / sw;
  endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchronizer for the SPI chip select plus edge detection.
module spi_cs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cs,
  output logic o_cs_fall,
  output logic o_cs_rise
);

  // [1:0] is the synchronizer, [2] holds the previous synchronized level
  logic [2:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], i_cs};
  end

  assign o_cs_fall =  r_sync[2] & ~r_sync[1];
  assign o_cs_rise = ~r_sync[2] &  r_sync[1];

endmodule

// File: rtl/pu_slave_spi_ctrl.sv
// Slave SPI controller: double-buffered TX/RX word banks exchanged at
// computational-cycle boundaries, byte stream to/from an SPI driver.
module pu_slave_spi_ctrl
  import pu_slave_spi_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ATTR_WIDTH     = 4,
  parameter int SPI_DATA_WIDTH = DEF_SPI_WIDTH,
  parameter int BUF_SIZE       = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signal_cycle,
  input  logic                      signal_wr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [ATTR_WIDTH-1:0]     attr_in,
  input  logic                      signal_oe,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [ATTR_WIDTH-1:0]     attr_out,
  output logic                      flag_start,
  output logic                      flag_stop,
  input  logic                      spi_ready,
  input  logic [SPI_DATA_WIDTH-1:0] spi_rx_byte,
  output logic [SPI_DATA_WIDTH-1:0] spi_tx_byte,
  input  logic                      cs
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH, SPI_DATA_WIDTH);
  localparam int TOTAL = BUF_SIZE * BPW;
  localparam int PTR_W = $clog2(BUF_SIZE + 1);
  localparam int IDX_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int K_W   = $clog2(TOTAL + 1);
  localparam logic [PTR_W-1:0]      PTR_END   = PTR_W'(BUF_SIZE);
  localparam logic [K_W-1:0]        K_END     = K_W'(TOTAL);
  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'({SPI_DATA_WIDTH{1'b1}});

  state_t                    r_state;
  logic                      r_pend, r_fall_pend, r_start, r_stop;
  logic [DATA_WIDTH-1:0]     r_stx   [BUF_SIZE];
  logic [DATA_WIDTH-1:0]     r_sptx  [BUF_SIZE];
  logic [DATA_WIDTH-1:0]     r_srx   [BUF_SIZE];
  logic [DATA_WIDTH-1:0]     r_sysrx [BUF_SIZE];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [K_W-1:0]            r_k;
  logic                      r_ovf, r_invalid;
  logic [DATA_WIDTH-1:0]     r_dout;
  logic [ATTR_WIDTH-1:0]     r_aout;
  logic [SPI_DATA_WIDTH-1:0] r_tx;

  logic                      w_fall, w_rise, w_swap, w_rx_hit, w_rx_ok;
  logic [K_W-1:0]            w_k_nxt;
  logic [IDX_W-1:0]          w_rx_idx;
  logic [DATA_WIDTH-1:0]     w_rx_word, w_tx_word;
  logic [SPI_DATA_WIDTH-1:0] w_tx_byte;
  int                        w_rx_sh, w_tx_sh;
  logic                      w_unused_attr;

  assign w_unused_attr = ^attr_in;

  spi_cs_sync u_cs_sync (
    .clk       (clk),
    .rst_n     (rst),
    .i_cs      (cs),
    .o_cs_fall (w_fall),
    .o_cs_rise (w_rise)
  );

  // spi_tx_byte is computed from the next byte slot so it lands one cycle after spi_ready
  always_comb begin
    w_swap    = (r_state == ST_SWAP);
    w_rx_hit  = (r_state == ST_XFER) && spi_ready;
    w_rx_ok   = w_rx_hit && (r_k < K_END);
    w_k_nxt   = w_swap ? '0 : (w_rx_ok ? r_k + K_W'(1) : r_k);
    w_rx_idx  = IDX_W'(int'(r_k) / BPW);
    w_rx_sh   = (BPW - 1 - int'(r_k) % BPW) * SPI_DATA_WIDTH;
    w_rx_word = (r_srx[w_rx_idx] & ~(BYTE_MASK << w_rx_sh))
              | (DATA_WIDTH'(spi_rx_byte) << w_rx_sh);
    w_tx_sh   = (BPW - 1 - int'(w_k_nxt) % BPW) * SPI_DATA_WIDTH;
    w_tx_word = '0;
    if (w_swap)               w_tx_word = r_stx[0];
    else if (w_k_nxt < K_END) w_tx_word = r_sptx[IDX_W'(int'(w_k_nxt) / BPW)];
    w_tx_byte = SPI_DATA_WIDTH'(w_tx_word >> w_tx_sh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pend      <= 1'b0;
      r_fall_pend <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_fall || r_fall_pend) begin
            r_state     <= ST_XFER;
            r_start     <= 1'b1;
            r_fall_pend <= 1'b0;
            r_pend      <= signal_cycle;
          end else if (signal_cycle) begin
            r_state <= ST_SWAP;
          end
        end
        ST_XFER: begin
          if (signal_cycle) r_pend <= 1'b1;
          if (w_rise) begin
            r_stop  <= 1'b1;
            r_state <= (r_pend || signal_cycle) ? ST_SWAP : ST_IDLE;
          end
        end
        ST_SWAP: begin
          // a cs fall seen here would otherwise be lost
          r_state     <= ST_IDLE;
          r_pend      <= 1'b0;
          r_fall_pend <= w_fall;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Swap assignments come last so they override same-cycle pointer updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        r_stx[i]   <= '0;
        r_sptx[i]  <= '0;
        r_srx[i]   <= '0;
        r_sysrx[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_k       <= '0;
      r_ovf     <= 1'b0;
      r_invalid <= 1'b0;
      r_dout    <= '0;
      r_aout    <= '0;
      r_tx      <= '0;
    end else begin
      if (signal_wr && (r_wr_ptr < PTR_END)) begin
        r_stx[IDX_W'(r_wr_ptr)] <= data_in;
        r_wr_ptr                <= r_wr_ptr + PTR_W'(1);
      end
      r_dout <= '0;
      r_aout <= '0;
      if (signal_oe) begin
        r_aout <= ATTR_WIDTH'(r_invalid);
        if (r_rd_ptr < PTR_END) begin
          r_dout   <= r_sysrx[IDX_W'(r_rd_ptr)];
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
      if (w_rx_ok)              r_srx[w_rx_idx] <= w_rx_word;
      if (w_rx_hit && !w_rx_ok) r_ovf           <= 1'b1;
      r_k  <= w_k_nxt;
      r_tx <= w_tx_byte;
      if (w_swap) begin
        for (int i = 0; i < BUF_SIZE; i++) begin
          r_sptx[i]  <= r_stx[i];
          r_sysrx[i] <= r_srx[i];
          r_srx[i]   <= '0;
        end
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_ovf     <= 1'b0;
        r_invalid <= r_ovf || ((int'(r_k) % BPW) != 0);
      end
    end
  end

  assign data_out    = r_dout;
  assign attr_out    = r_aout;
  assign flag_start  = r_start;
  assign flag_stop   = r_stop;
  assign spi_tx_byte = r_tx;

endmodule

// File: tb/tb_pu_slave_spi_ctrl.sv
// Randomized self-checking bench for pu_slave_spi_ctrl against a byte-list model.
module tb_pu_slave_spi_ctrl;
  import pu_slave_spi_pkg::*;

  localparam int BUF   = 6;
  localparam int BPW   = BYTES_PER_WORD;
  localparam int SLOTS = BUF * BPW;

  logic        clk = 1'b0, rst = 1'b0;
  logic        signal_cycle = 1'b0, signal_wr = 1'b0, signal_oe = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  attr_in = '0;
  logic [31:0] data_out;
  logic [3:0]  attr_out;
  logic        flag_start, flag_stop;
  logic        spi_ready = 1'b0;
  logic [7:0]  spi_rx_byte = '0;
  logic [7:0]  spi_tx_byte;
  logic        cs = 1'b1;

  always #5 clk = ~clk;

  pu_slave_spi_ctrl dut (
    .clk(clk), .rst(rst), .signal_cycle(signal_cycle), .signal_wr(signal_wr),
    .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
    .data_out(data_out), .attr_out(attr_out), .flag_start(flag_start),
    .flag_stop(flag_stop), .spi_ready(spi_ready), .spi_rx_byte(spi_rx_byte),
    .spi_tx_byte(spi_tx_byte), .cs(cs)
  );

  int          n_chk = 0, n_err = 0;
  logic [31:0] m_systx [BUF];
  logic [31:0] m_sptx  [BUF];
  logic [31:0] m_sysrx [BUF];
  logic [7:0]  m_rx [$];
  int          m_wcnt, m_rd;
  bit          m_inv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic void model_reset();
    for (int w = 0; w < BUF; w++) begin
      m_systx[w] = '0; m_sptx[w] = '0; m_sysrx[w] = '0;
    end
    m_rx.delete();
    m_wcnt = 0; m_rd = 0; m_inv = 1'b0;
  endfunction

  function automatic void model_swap();
    int n;
    n = m_rx.size();
    for (int w = 0; w < BUF; w++) begin
      m_sptx[w]  = m_systx[w];
      m_sysrx[w] = '0;
    end
    for (int k = 0; k < n && k < SLOTS; k++)
      m_sysrx[k / BPW] |= 32'(m_rx[k]) << (8 * (BPW - 1 - k % BPW));
    m_inv = (n > SLOTS) || (n % BPW != 0);
    m_rx.delete();
    m_wcnt = 0; m_rd = 0;
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] v;
    v = '0;
    if (m_rd < BUF) begin
      v = m_sysrx[m_rd];
      m_rd++;
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_tx(input int k);
    if (k >= SLOTS) return 8'h00;
    return 8'(m_sptx[k / BPW] >> (8 * (BPW - 1 - k % BPW)));
  endfunction

  task automatic wr(input logic [31:0] d);
    signal_wr = 1'b1; data_in = d; attr_in = 4'($urandom);
    cyc();
    signal_wr = 1'b0;
    if (m_wcnt < BUF) begin m_systx[m_wcnt] = d; m_wcnt++; end
  endtask

  task automatic rd_n(input int cnt, input string tag);
    for (int r = 0; r < cnt; r++) begin
      signal_oe = 1'b1; cyc(); signal_oe = 1'b0;
      chk({tag, "_data"}, data_out, model_read());
      chk({tag, "_attr"}, 32'(attr_out), 32'(m_inv));
    end
    cyc();
    chk({tag, "_idle_data"}, data_out, 32'h0);
    chk({tag, "_idle_attr"}, 32'(attr_out), 32'h0);
  endtask

  task automatic do_swap();
    signal_cycle = 1'b1; cyc(); signal_cycle = 1'b0; cyc();
    model_swap();
  endtask

  task automatic wait_start(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin cyc(); got = flag_start; end
    chk(tag, 32'(got), 32'h1);
  endtask

  task automatic xfer(input int n, input bit rnd, input bit pend);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      chk("tx_byte", 32'(spi_tx_byte), 32'(exp_tx(m_rx.size())));
      b = rnd ? 8'($urandom) : 8'(i + 1);
      spi_ready = 1'b1; spi_rx_byte = b;
      cyc();
      spi_ready = 1'b0;
      m_rx.push_back(b);
      repeat ($urandom_range(0, 2)) cyc();
    end
    chk("tx_byte_last", 32'(spi_tx_byte), 32'(exp_tx(m_rx.size())));
    if (pend) begin
      signal_cycle = 1'b1; cyc(); signal_cycle = 1'b0;
      signal_oe = 1'b1; cyc(); signal_oe = 1'b0;
      chk("xfer_read", data_out, model_read());
      repeat (3) cyc();
      signal_oe = 1'b1; cyc(); signal_oe = 1'b0;
      chk("xfer_read_late", data_out, model_read());
      chk("no_early_swap_tx", 32'(spi_tx_byte), 32'(exp_tx(m_rx.size())));
    end
  endtask

  // With a pending swap, the cycle showing flag_stop is the swap cycle itself
  task automatic cs_up(input bit pend);
    bit got;
    got = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin cyc(); got = flag_stop; end
    chk("flag_stop", 32'(got), 32'h1);
    if (pend) begin
      signal_oe = 1'b1; cyc(); signal_oe = 1'b0;
      chk("swap_cycle_read", data_out, model_read());
      chk("swap_cycle_attr", 32'(attr_out), 32'(m_inv));
      model_swap();
    end else begin
      do_swap();
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dout"},  data_out,           32'h0);
    chk({tag, "_attr"},  32'(attr_out),      32'h0);
    chk({tag, "_start"}, 32'(flag_start),    32'h0);
    chk({tag, "_stop"},  32'(flag_stop),     32'h0);
    chk({tag, "_tx"},    32'(spi_tx_byte),   32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int  nw, n, nrd;
    bit  pend, stop_seen;
    model_reset();
    repeat (3) cyc();
    chk_zero_outputs("reset");
    rst = 1'b1;
    repeat (2) cyc();

    // Known words out, counting bytes in
    wr(32'h11223344); wr(32'hAABBCCDD);
    do_swap();
    cs = 1'b0; wait_start("start_t1");
    xfer(12, 1'b0, 1'b0);
    cs_up(1'b0);
    rd_n(4, "t1");

    // cs falls while in SWAP; system-TX must still hold the earlier words
    cs = 1'b0; cyc();
    signal_cycle = 1'b1; cyc(); signal_cycle = 1'b0;
    model_swap();
    wait_start("start_in_swap");
    xfer(5, 1'b1, 1'b0);
    cs_up(1'b0);
    rd_n(2, "t_partial");

    // Overflow with a swap requested mid-transfer
    cs = 1'b0; wait_start("start_ovf");
    xfer(25, 1'b1, 1'b1);
    cs_up(1'b1);
    rd_n(7, "t_ovf");

    // Write/read saturation
    for (int j = 0; j < 7; j++) wr($urandom);
    do_swap();
    cs = 1'b0; wait_start("start_sat");
    xfer(26, 1'b1, 1'b0);
    cs_up(1'b0);
    rd_n(7, "t_sat");

    for (int it = 0; it < 6; it++) begin
      nw   = $urandom_range(0, 7);
      n    = $urandom_range(0, 26);
      pend = 1'($urandom);
      nrd  = $urandom_range(0, 7);
      for (int j = 0; j < nw; j++) wr($urandom);
      do_swap();
      spi_ready = 1'b1; spi_rx_byte = 8'($urandom); cyc(); spi_ready = 1'b0;
      cs = 1'b0; wait_start("start_rand");
      xfer(n, 1'b1, pend);
      cs_up(pend);
      rd_n(nrd, "rand");
    end

    // Reset in the middle of a transfer
    cs = 1'b0; wait_start("start_rst");
    xfer(2, 1'b1, 1'b0);
    rst = 1'b0; #1;
    chk_zero_outputs("mid_rst");
    cs = 1'b1; stop_seen = 1'b0;
    repeat (3) begin cyc(); stop_seen |= flag_stop; end
    rst = 1'b1;
    repeat (4) begin cyc(); stop_seen |= flag_stop; end
    chk("no_flag_stop", 32'(stop_seen), 32'h0);
    model_reset();
    chk("post_rst_tx", 32'(spi_tx_byte), 32'h0);
    rd_n(2, "post_rst");

    wr(32'hCAFEF00D);
    do_swap();
    cs = 1'b0; wait_start("start_post");
    xfer(4, 1'b1, 1'b0);
    cs_up(1'b0);
    rd_n(2, "post");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
